// File: rtl/regfile_scoreboard_pkg.sv
// Shared core package for the register-file scoreboard: sizes, address type,
// write-back port bundle and a duplicate-write-back helper.
`default_nettype none

package regfile_scoreboard_pkg;

  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = 5;

  typedef logic [ADDR_W-1:0] reg_addr_t;

  typedef struct packed {
    logic      valid;
    reg_addr_t addr;
  } wb_port_t;

  // Both ports retiring the same real register in one cycle is a protocol error
  function automatic logic wb_is_dup(input wb_port_t a, input wb_port_t b);
    return a.valid && b.valid && (a.addr == b.addr) && (a.addr != '0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/regfile_scoreboard_if.sv
// Issue / write-back / status bundle between the decoder side (master) and
// the scoreboard (slave).
`default_nettype none

interface regfile_scoreboard_if;
  import regfile_scoreboard_pkg::*;

  logic            issue_valid_i;
  reg_addr_t       rs1_i;
  reg_addr_t       rs2_i;
  reg_addr_t       rd_i;
  logic            rd_we_i;
  logic            flush_i;
  logic            wb0_valid_i;
  reg_addr_t       wb0_addr_i;
  logic            wb1_valid_i;
  reg_addr_t       wb1_addr_i;
  logic            stall_o;
  logic            issue_o;
  logic            busy_o;
  logic [ADDR_W:0] pend_cnt_o;
  logic            err_o;

  modport master (
    output issue_valid_i, rs1_i, rs2_i, rd_i, rd_we_i, flush_i,
    output wb0_valid_i, wb0_addr_i, wb1_valid_i, wb1_addr_i,
    input  stall_o, issue_o, busy_o, pend_cnt_o, err_o
  );

  modport slave (
    input  issue_valid_i, rs1_i, rs2_i, rd_i, rd_we_i, flush_i,
    input  wb0_valid_i, wb0_addr_i, wb1_valid_i, wb1_addr_i,
    output stall_o, issue_o, busy_o, pend_cnt_o, err_o
  );

endinterface

`default_nettype wire

// File: rtl/regfile_scoreboard_hazard_check.sv
// hazard_check: combinational RAW/WAW stall decision against the pending vector.
// SCOREBOARD_BYPASS_EN: registers retiring this cycle count as not pending.
`default_nettype none

module hazard_check #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5
) (
  input  wire logic [NUM_REGS-1:0] pend_i,
  input  wire logic [NUM_REGS-1:0] clr_i,
  input  wire logic                issue_valid_i,
  input  wire logic [ADDR_W-1:0]   rs1_i,
  input  wire logic [ADDR_W-1:0]   rs2_i,
  input  wire logic [ADDR_W-1:0]   rd_i,
  input  wire logic                rd_we_i,
  output logic                     stall_o
);

  logic [NUM_REGS-1:0] pend_eff;

`ifdef SCOREBOARD_BYPASS_EN
  assign pend_eff = pend_i & ~clr_i;
`else
  logic unused_clr;
  assign unused_clr = ^clr_i;
  assign pend_eff   = pend_i;
`endif

  assign stall_o = issue_valid_i &
                   (pend_eff[rs1_i] | pend_eff[rs2_i] | (rd_we_i & pend_eff[rd_i]));

endmodule

`default_nettype wire

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: tracks outstanding register writes, stalls hazardous issue,
// flags write-back protocol errors. Optional macro: SCOREBOARD_BYPASS_EN.
`default_nettype none

module regfile_scoreboard #(
  parameter int NUM_REGS = regfile_scoreboard_pkg::NUM_REGS,
  parameter int ADDR_W   = regfile_scoreboard_pkg::ADDR_W
) (
  input  wire logic           clk_i,
  input  wire logic           rsn_i,
  regfile_scoreboard_if.slave sb
);
  import regfile_scoreboard_pkg::wb_port_t;
  import regfile_scoreboard_pkg::wb_is_dup;

  localparam int CNT_W = ADDR_W + 1;

  logic [NUM_REGS-1:0] pend_q, pend_d;
  logic [NUM_REGS-1:0] set_mask, clr0_mask, clr1_mask, clr_mask;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                err_q, err_d;
  logic                stall, issue, dup;
  logic                clr0_hit, clr1_hit, nonpend0, nonpend1, inc;
  wb_port_t            wb0, wb1;

  assign wb0 = '{valid: sb.wb0_valid_i, addr: sb.wb0_addr_i};
  assign wb1 = '{valid: sb.wb1_valid_i, addr: sb.wb1_addr_i};

  hazard_check #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_hazard_check (
    .pend_i        (pend_q),
    .clr_i         (clr_mask),
    .issue_valid_i (sb.issue_valid_i),
    .rs1_i         (sb.rs1_i),
    .rs2_i         (sb.rs2_i),
    .rd_i          (sb.rd_i),
    .rd_we_i       (sb.rd_we_i),
    .stall_o       (stall)
  );

  assign issue = sb.issue_valid_i & ~stall;

  // x0 is hard-wired zero: never set, never cleared
  always_comb begin
    set_mask  = '0;
    clr0_mask = '0;
    clr1_mask = '0;
    if (issue && sb.rd_we_i && (sb.rd_i != '0)) set_mask[sb.rd_i]   = 1'b1;
    if (wb0.valid && (wb0.addr != '0))          clr0_mask[wb0.addr] = 1'b1;
    if (wb1.valid && (wb1.addr != '0))          clr1_mask[wb1.addr] = 1'b1;
  end

  assign clr_mask = clr0_mask | clr1_mask;
  assign dup      = wb_is_dup(wb0, wb1);
  assign clr0_hit = |(clr0_mask & pend_q);
  assign clr1_hit = |(clr1_mask & pend_q) & ~dup;
  assign nonpend0 = |clr0_mask & ~(|(clr0_mask & pend_q));
  assign nonpend1 = |clr1_mask & ~(|(clr1_mask & pend_q));
  // A set on a bit that survives this cycle's clears adds nothing to the count
  assign inc      = |set_mask & ~(|(set_mask & pend_q & ~clr_mask));

  always_comb begin
    pend_d = (pend_q & ~clr_mask) | set_mask;
    cnt_d  = cnt_q + CNT_W'(inc) - CNT_W'(clr0_hit) - CNT_W'(clr1_hit);
    err_d  = err_q | nonpend0 | nonpend1 | dup;
    if (sb.flush_i) begin
      pend_d = '0;
      cnt_d  = '0;
      err_d  = err_q;
    end
  end

  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      pend_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

  assign sb.stall_o    = stall;
  assign sb.issue_o    = issue;
  assign sb.busy_o     = (cnt_q != '0);
  assign sb.pend_cnt_o = cnt_q;
  assign sb.err_o      = err_q;

endmodule

`default_nettype wire
